// File: rtl/hazard_ctrl.sv
// Hazard unit: forwarding selects, load-use/branch interlocks,
// data-bus wait FSM and multi-cycle mul/div stall counter.
module hazard_ctrl (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       MulDivStartE,
  input  logic       MulDivIsDivE,
  input  logic       MemReqM,
  input  logic       d_data_ok,
  input  logic       i_wait,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       StallW,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       d_req,
  output logic       MulDivBusy
);

  typedef enum logic [1:0] {
    D_IDLE,
    D_WAIT,
    D_DONE
  } dState_t;

  dState_t    dState;
  dState_t    dNext;
  logic [5:0] cnt;
  logic       done;
  logic       lwstall;
  logic       brstall;
  logic       dstall;
  logic       freeze;
  logic       mdStart;
  logic       mdstall;

  function automatic logic hit(input logic [4:0] a,
                               input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && hit(WriteRegM, RsE))
      ForwardAE = 2'b10;
    else if (RegWriteW && hit(WriteRegW, RsE))
      ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && hit(WriteRegM, RtE))
      ForwardBE = 2'b10;
    else if (RegWriteW && hit(WriteRegW, RtE))
      ForwardBE = 2'b01;
  end

  assign ForwardAD = RegWriteM && hit(WriteRegM, RsD);
  assign ForwardBD = RegWriteM && hit(WriteRegM, RtD);

  assign lwstall = MemtoRegE && RegWriteE &&
                   (hit(WriteRegE, RsD) || hit(WriteRegE, RtD));

  assign brstall = BranchD &&
    ((RegWriteE && (hit(WriteRegE, RsD) || hit(WriteRegE, RtD))) ||
     (MemtoRegM && (hit(WriteRegM, RsD) || hit(WriteRegM, RtD))));

  assign dstall = ((dState == D_IDLE) && MemReqM && !d_data_ok) ||
                  ((dState == D_WAIT) && !d_data_ok);
  assign freeze = dstall || i_wait;

  assign mdStart = (cnt == 6'd0) && !done && MulDivStartE;
  assign mdstall = mdStart || (cnt != 6'd0);

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    StallW = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    if (!resetn) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end else if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      StallW = 1'b1;
    end else if (mdstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (lwstall || brstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign MulDivBusy = resetn && mdstall;

  // Only i_wait can hold M besides the data FSM itself.
  always_comb begin
    dNext = dState;
    d_req = 1'b0;
    case (dState)
      D_IDLE: begin
        d_req = MemReqM;
        if (MemReqM && !d_data_ok && !i_wait)
          dNext = D_WAIT;
        else if (MemReqM && d_data_ok && i_wait)
          dNext = D_DONE;
      end
      D_WAIT: begin
        if (d_data_ok)
          dNext = i_wait ? D_DONE : D_IDLE;
      end
      D_DONE: begin
        if (!StallM)
          dNext = D_IDLE;
      end
      default: dNext = D_IDLE;
    endcase
    if (!resetn)
      d_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dState <= D_IDLE;
      cnt    <= 6'd0;
      done   <= 1'b0;
    end else begin
      dState <= dNext;
      if (mdStart)
        cnt <= MulDivIsDivE ? 6'd31 : 6'd2;
      else if (cnt != 6'd0)
        cnt <= cnt - 6'd1;
      if (cnt == 6'd1)
        done <= 1'b1;
      else if (!StallE)
        done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector table plus multi-cycle sequences
// for hazard_ctrl.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM, BranchD;
  logic       MulDivStartE, MulDivIsDivE;
  logic       MemReqM, d_data_ok, i_wait;
  logic       StallF, StallD, StallE, StallM, StallW;
  logic       FlushD, FlushE, FlushM, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD;
  logic       d_req, MulDivBusy;

  int nVec = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .resetn(resetn),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
    .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD),
    .MulDivStartE(MulDivStartE), .MulDivIsDivE(MulDivIsDivE),
    .MemReqM(MemReqM), .d_data_ok(d_data_ok), .i_wait(i_wait),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .d_req(d_req), .MulDivBusy(MulDivBusy)
  );

  typedef struct {
    string      name;
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic       rwE, rwM, rwW, m2rE, m2rM, brD;
    logic       memReq, ok, iw;
    logic [4:0] stall;
    logic [3:0] flush;
    logic [1:0] fae, fbe;
    logic       fad, fbd, dreq;
  } vec_t;

  vec_t vt[$];

  function automatic logic [4:0] stalls();
    return {StallF, StallD, StallE, StallM, StallW};
  endfunction

  function automatic logic [3:0] flushes();
    return {FlushD, FlushE, FlushM, FlushW};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic idle();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
    MulDivStartE = 0; MulDivIsDivE = 0;
    MemReqM = 0; d_data_ok = 0; i_wait = 0;
  endtask

  function automatic vec_t mk(string nm);
    vec_t v;
    v.name = nm;
    v.rsD = 0; v.rtD = 0; v.rsE = 0; v.rtE = 0;
    v.wrE = 0; v.wrM = 0; v.wrW = 0;
    v.rwE = 0; v.rwM = 0; v.rwW = 0;
    v.m2rE = 0; v.m2rM = 0; v.brD = 0;
    v.memReq = 0; v.ok = 0; v.iw = 0;
    v.stall = 0; v.flush = 0; v.fae = 0; v.fbe = 0;
    v.fad = 0; v.fbd = 0; v.dreq = 0;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    idle();
    resetn = 0;

    v = mk("zero");
    vt.push_back(v);
    v = mk("fwdM"); v.rwM = 1; v.rwW = 1;
    v.wrM = 5; v.wrW = 5; v.rsE = 5; v.fae = 2'b10;
    vt.push_back(v);
    v = mk("fwdR0"); v.rwM = 1; v.rwW = 1;
    v.wrM = 5; v.wrW = 5; v.rsE = 0;
    vt.push_back(v);
    v = mk("fwdW"); v.rwW = 1; v.wrW = 7;
    v.rsE = 7; v.rtE = 7; v.fae = 2'b01; v.fbe = 2'b01;
    vt.push_back(v);
    v = mk("fwdWnoM"); v.wrM = 7; v.rwW = 1; v.wrW = 7;
    v.rtE = 7; v.fbe = 2'b01;
    vt.push_back(v);
    v = mk("fwdD"); v.rwM = 1; v.wrM = 3;
    v.rsD = 3; v.rtD = 3; v.fad = 1; v.fbd = 1;
    vt.push_back(v);
    v = mk("loaduse"); v.m2rE = 1; v.rwE = 1;
    v.wrE = 8; v.rsD = 8; v.stall = 5'b11000; v.flush = 4'b0100;
    vt.push_back(v);
    v = mk("loaduseNoRW"); v.m2rE = 1; v.wrE = 8; v.rsD = 8;
    vt.push_back(v);
    v = mk("loaduseR0"); v.m2rE = 1; v.rwE = 1;
    vt.push_back(v);
    v = mk("brE"); v.brD = 1; v.rwE = 1; v.wrE = 9; v.rtD = 9;
    v.stall = 5'b11000; v.flush = 4'b0100;
    vt.push_back(v);
    v = mk("brMload"); v.brD = 1; v.m2rM = 1; v.rwM = 1;
    v.wrM = 4; v.rsD = 4; v.fad = 1;
    v.stall = 5'b11000; v.flush = 4'b0100;
    vt.push_back(v);
    v = mk("brMalu"); v.brD = 1; v.rwM = 1; v.wrM = 4;
    v.rsD = 4; v.fad = 1;
    vt.push_back(v);
    v = mk("iwaitOverLw"); v.iw = 1; v.m2rE = 1; v.rwE = 1;
    v.wrE = 8; v.rsD = 8; v.stall = 5'b11111;
    vt.push_back(v);
    v = mk("memHit"); v.memReq = 1; v.ok = 1; v.dreq = 1;
    vt.push_back(v);

    // reset overrides everything, including pending hazards
    @(negedge clk);
    MemReqM = 1; i_wait = 1; MulDivStartE = 1;
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RsD = 8;
    #1;
    chk("rstStall", stalls(), 5'b00000);
    chk("rstFlush", flushes(), 4'b1111);
    chk("rstDreq", d_req, 0);
    chk("rstBusy", MulDivBusy, 0);
    step();
    step();
    idle();
    resetn = 1;
    #1;
    chk("postRstStall", stalls(), 5'b00000);
    chk("postRstBusy", MulDivBusy, 0);

    foreach (vt[i]) begin
      @(negedge clk);
      idle();
      RsD = vt[i].rsD; RtD = vt[i].rtD;
      RsE = vt[i].rsE; RtE = vt[i].rtE;
      WriteRegE = vt[i].wrE; WriteRegM = vt[i].wrM;
      WriteRegW = vt[i].wrW;
      RegWriteE = vt[i].rwE; RegWriteM = vt[i].rwM;
      RegWriteW = vt[i].rwW;
      MemtoRegE = vt[i].m2rE; MemtoRegM = vt[i].m2rM;
      BranchD = vt[i].brD;
      MemReqM = vt[i].memReq; d_data_ok = vt[i].ok;
      i_wait = vt[i].iw;
      #1;
      chk({vt[i].name, ".stall"}, stalls(), vt[i].stall);
      chk({vt[i].name, ".flush"}, flushes(), vt[i].flush);
      chk({vt[i].name, ".fae"}, ForwardAE, vt[i].fae);
      chk({vt[i].name, ".fbe"}, ForwardBE, vt[i].fbe);
      chk({vt[i].name, ".fad"}, ForwardAD, vt[i].fad);
      chk({vt[i].name, ".fbd"}, ForwardBD, vt[i].fbd);
      chk({vt[i].name, ".dreq"}, d_req, vt[i].dreq);
    end

    // divide: 32 stall cycles, then no restart
    @(negedge clk);
    idle();
    MulDivStartE = 1; MulDivIsDivE = 1;
    for (int k = 0; k < 32; k++) begin
      #1;
      chk($sformatf("div%0d.stall", k), stalls(), 5'b11100);
      chk($sformatf("div%0d.flush", k), flushes(), 4'b0010);
      chk($sformatf("div%0d.busy", k), MulDivBusy, 1);
      step();
    end
    #1;
    chk("divEnd.stall", stalls(), 5'b00000);
    chk("divEnd.busy", MulDivBusy, 0);
    step();
    MulDivStartE = 0; MulDivIsDivE = 0;
    #1;
    chk("divAfter.busy", MulDivBusy, 0);

    // multiply: 3 stall cycles
    step();
    MulDivStartE = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("mul%0d.stallE", k), StallE, 1);
      chk($sformatf("mul%0d.flushM", k), FlushM, 1);
      step();
    end
    #1;
    chk("mulEnd.stallE", StallE, 0);
    chk("mulEnd.busy", MulDivBusy, 0);
    step();
    MulDivStartE = 0;

    // data wait: response three cycles after the request
    step();
    MemReqM = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("dw%0d.dreq", k), d_req, k == 0);
      chk($sformatf("dw%0d.stall", k), stalls(), 5'b11111);
      step();
    end
    d_data_ok = 1;
    #1;
    chk("dwOk.dreq", d_req, 0);
    chk("dwOk.stall", stalls(), 5'b00000);
    step();
    MemReqM = 0; d_data_ok = 0;
    #1;
    chk("dwAfter.stall", stalls(), 5'b00000);

    // response lands while fetch is still outstanding
    step();
    MemReqM = 1;
    #1;
    chk("sim0.dreq", d_req, 1);
    step();
    i_wait = 1; d_data_ok = 1;
    #1;
    chk("sim1.dreq", d_req, 0);
    chk("sim1.stall", stalls(), 5'b11111);
    step();
    d_data_ok = 0;
    #1;
    chk("sim2.dreq", d_req, 0);
    chk("sim2.stall", stalls(), 5'b11111);
    step();
    i_wait = 0;
    #1;
    chk("sim3.dreq", d_req, 0);
    chk("sim3.stall", stalls(), 5'b00000);
    step();
    d_data_ok = 1;
    #1;
    chk("sim4.dreqIdle", d_req, 1);
    chk("sim4.stall", stalls(), 5'b00000);
    step();
    MemReqM = 0; d_data_ok = 0;

    // reset in the middle of a divide (cnt = 10)
    step();
    MulDivStartE = 1; MulDivIsDivE = 1;
    for (int k = 0; k < 22; k++) step();
    #1;
    chk("rdiv.busyBefore", MulDivBusy, 1);
    resetn = 0;
    #1;
    chk("rdiv.busyInRst", MulDivBusy, 0);
    chk("rdiv.flushInRst", flushes(), 4'b1111);
    step();
    resetn = 1; MulDivStartE = 0; MulDivIsDivE = 0;
    #1;
    chk("rdiv.busyAfter", MulDivBusy, 0);
    chk("rdiv.stallAfter", stalls(), 5'b00000);
    step();
    #1;
    chk("rdiv.busyLater", MulDivBusy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
